mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch requester (PC/fetch stage) and the data requester (load/store unit) of the 2-stage RV32I pipeline.
- Sequences each transaction to completion and returns read data with a one-cycle valid pulse.
- Discards fetch results that were invalidated by a branch/jump flush.
- Gives data accesses priority, with a starvation limit that guarantees fetch progress.

Parameters:
- STARVE_LIMIT, 4: max consecutive data grants while if_req is pending before one fetch grant is forced. Legal range 1..15.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- if_req  input  1  fetch request, held high until if_valid
- if_addr  input  32  fetch byte address
- if_flush  input  1  branch/jump redirect; drop the in-flight fetch result
- if_rdata  output  32  fetched instruction
- if_valid  output  1  one-cycle pulse, if_rdata valid
- d_req  input  1  data request, held high until d_valid
- d_we  input  1  1 = store, 0 = load
- d_mask  input  4  byte enables for stores
- d_addr  input  32  data byte address
- d_wdata  input  32  store data
- d_rdata  output  32  load data
- d_valid  output  1  one-cycle pulse, load data ready or store accepted
- mem_req  output  1  memory transaction request
- mem_we  output  1  memory write enable
- mem_mask  output  4  memory byte enables
- mem_addr  output  32  memory address
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data, valid when mem_ack is high
- mem_ack  input  1  one-cycle completion pulse

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. While rst is low:
  - state = IDLE; starve_cnt = 0; drop_flag = 0.
  - All outputs are 0: mem_req, mem_we, mem_mask, mem_addr, mem_wdata, if_rdata, if_valid, d_rdata, d_valid.
  - An assertion of rst mid-transaction abandons that transaction; no valid pulse is produced.
- States: IDLE, IF_BUSY, D_BUSY.
- Effective requests:
  - eff_if = if_req & ~if_valid.
  - eff_d = d_req & ~d_valid.
  - A requester's req is ignored in the cycle its own valid is high (holdoff against a stale req).
- IDLE grant rules, evaluated at the clock edge:
  - eff_d and eff_if both high, starve_cnt < STARVE_LIMIT: grant data, starve_cnt++.
  - eff_d and eff_if both high, starve_cnt == STARVE_LIMIT: grant fetch, starve_cnt = 0.
  - Only eff_d high: grant data, starve_cnt = 0.
  - Only eff_if high: grant fetch, starve_cnt = 0.
  - Neither high: stay in IDLE; mem_req = 0.
- On a grant:
  - All mem_* outputs are registered from the winning requester's inputs at the grant edge.
  - mem_req goes high in the next cycle; next state is D_BUSY or IF_BUSY.
  - A fetch grant drives mem_we = 0 and mem_mask = 4'hF.
- BUSY:
  - mem_* outputs are held stable until mem_ack. Requester input changes are ignored.
  - On mem_ack: mem_req drops at that edge and the state returns to IDLE.
- Minimum transaction is 3 cycles: grant edge, mem_ack cycle, valid cycle. There is no back-to-back grant in the valid cycle for the same requester.
- Completion, D_BUSY:
  - d_valid pulses in the cycle after mem_ack.
  - For a load, d_rdata latches mem_rdata.
  - For a store, d_rdata keeps its previous value.
- Completion, IF_BUSY:
  - If drop_flag = 0: if_rdata latches mem_rdata and if_valid pulses in the cycle after mem_ack.
  - If drop_flag = 1: no if_valid, if_rdata unchanged, drop_flag cleared.
- Flush:
  - if_flush in IF_BUSY, including the mem_ack cycle, sets drop_flag. The memory transaction still completes; the bus is never aborted.
  - if_flush in IDLE or D_BUSY has no effect.
  - An if_valid pulse already registered is not retracted.
- mem_ack in IDLE is ignored.
- Stalls visible to the PC follow implicitly from req held high without valid. There is no separate stall output.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_ack after 2 cycles with mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0, mem_mask=F; if_rdata=0x00500093 and if_valid pulses 1 cycle after ack.
- Store then load:
  - d_req store, addr 0x2000, wdata 0xDEADBEEF, mask 4'b0011 -> mem_we=1, mem_mask=0011, d_valid pulse, d_rdata unchanged.
  - Load from 0x2000 with mem_rdata=0x0000BEEF -> d_rdata=0x0000BEEF.
- Contention/starvation: if_req and d_req held high continuously, zero-wait ack, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Flush mid-fetch: fetch of 0x104 granted, if_flush pulsed 1 cycle before mem_ack -> no if_valid for 0x104; the next fetch of 0x200 returns normally with if_valid.
- Reset mid-transaction: rst low during D_BUSY before ack -> all outputs 0 immediately; after release, a late mem_ack produces no d_valid; a new d_req is granted normally.
- Holdoff: requester keeps if_req high in its if_valid cycle -> no regrant that cycle; grant on the next cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the three ports of the memory arbiter: the fetch requester
// (if_*), the data requester (d_*) and the unified memory port (mem_*).
// state_dbg exposes the arbiter FSM state so checkers can bind to it.
//
// Handshake: a requester raises req with its address and data, and keeps
// req and those signals stable until its valid pulses for one cycle. The
// memory sees mem_req with stable mem_* signals until mem_ack pulses for
// one cycle. mem_rdata is only meaningful while mem_ack is high.
//
// Modports:
//   slave  - the arbiter: consumes requests and memory responses.
//   master - the environment: requesters plus memory.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_mask;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  state_dbg;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_mask, d_addr, d_wdata,
           mem_rdata, mem_ack,
    output if_rdata, if_valid, d_rdata, d_valid,
           mem_req, mem_we, mem_mask, mem_addr, mem_wdata, state_dbg
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_mask, d_addr, d_wdata,
           mem_rdata, mem_ack,
    input  if_rdata, if_valid, d_rdata, d_valid,
           mem_req, mem_we, mem_mask, mem_addr, mem_wdata, state_dbg
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between instruction fetch and the load/store unit.
// Data accesses win contention, but after STARVE_LIMIT consecutive data
// grants with fetch waiting, one fetch grant is forced. Fetch results that
// were flushed while in flight are completed on the bus but discarded.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-low reset
//   bus  - mem_port_arbiter_if.slave (fetch, data and memory signals)
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY  = 2'd2;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]  state;
  logic [3:0]  starve_cnt;
  logic        drop_flag;

  logic        mem_req_q;
  logic        mem_we_q;
  logic [3:0]  mem_mask_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] if_rdata_q;
  logic        if_valid_q;
  logic [31:0] d_rdata_q;
  logic        d_valid_q;

  // A requester's req is ignored while its own valid is high, since the
  // requester has not yet had a cycle to drop or update it.
  logic eff_if;
  logic eff_d;
  // The cycle carrying a valid pulse is a turnaround cycle: no grant is
  // issued, so every transaction spans grant, ack and valid cycles.
  logic turnaround;
  logic grant_d;

  assign eff_if     = bus.if_req & ~if_valid_q;
  assign eff_d      = bus.d_req & ~d_valid_q;
  assign turnaround = if_valid_q | d_valid_q;
  assign grant_d    = eff_d & (~eff_if | (starve_cnt < LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      starve_cnt  <= 4'd0;
      drop_flag   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_mask_q  <= 4'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      if_valid_q  <= 1'b0;
      d_rdata_q   <= 32'd0;
      d_valid_q   <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (!turnaround) begin
            if (grant_d) begin
              // Count only data grants that held off a waiting fetch.
              starve_cnt  <= eff_if ? starve_cnt + 4'd1 : 4'd0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.d_we;
              mem_mask_q  <= bus.d_mask;
              mem_addr_q  <= bus.d_addr;
              mem_wdata_q <= bus.d_wdata;
              state       <= D_BUSY;
            end else if (eff_if) begin
              starve_cnt  <= 4'd0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b0;
              mem_mask_q  <= 4'hF;
              mem_addr_q  <= bus.if_addr;
              mem_wdata_q <= 32'd0;
              state       <= IF_BUSY;
            end
          end
        end
        IF_BUSY: begin
          if (bus.if_flush) drop_flag <= 1'b1;
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state     <= IDLE;
            // A flush in the ack cycle itself also kills this result.
            if (drop_flag || bus.if_flush) begin
              drop_flag <= 1'b0;
            end else begin
              if_rdata_q <= bus.mem_rdata;
              if_valid_q <= 1'b1;
            end
          end
        end
        D_BUSY: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state     <= IDLE;
            d_valid_q <= 1'b1;
            if (!mem_we_q) d_rdata_q <= bus.mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_mask  = mem_mask_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: single fetch, store/load, data vs
// fetch contention with starvation limit 4, flush of an in-flight fetch,
// reset during a data transaction and req holdoff in the valid cycle.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;
  logic [31:0] exp_q[$];

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // drivers: inputs change and outputs are sampled 1 time unit after posedge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (bus.mem_req !== 1'b1) chk({tag, "_timeout"}, 32'(bus.mem_req), 32'd1);
  endtask

  task automatic ack(input logic [31:0] rdata);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    step();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
  endtask

  task automatic drive_d(input logic req, input logic we, input logic [3:0] mask,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.d_req   = req;
    bus.d_we    = we;
    bus.d_mask  = mask;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b0;
    bus.if_req = 1'b0;
    bus.if_addr = 32'd0;
    bus.if_flush = 1'b0;
    drive_d(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    bus.mem_rdata = 32'd0;
    bus.mem_ack = 1'b0;

    // reset state
    step();
    step();
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_mask", 32'(bus.mem_mask), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_d_valid", 32'(bus.d_valid), 32'd0);
    chk("rst_state", 32'(bus.state_dbg), 32'd0);
    rst = 1'b1;
    step();

    // single fetch, ack two cycles after grant
    bus.if_req = 1'b1;
    bus.if_addr = 32'h100;
    step();
    chk("f_mem_req", 32'(bus.mem_req), 32'd1);
    chk("f_mem_addr", bus.mem_addr, 32'h100);
    chk("f_mem_we", 32'(bus.mem_we), 32'd0);
    chk("f_mem_mask", 32'(bus.mem_mask), 32'hF);
    chk("f_state", 32'(bus.state_dbg), 32'd1);
    step();
    chk("f_hold_req", 32'(bus.mem_req), 32'd1);
    chk("f_no_early_valid", 32'(bus.if_valid), 32'd0);
    ack(32'h00500093);
    chk("f_if_valid", 32'(bus.if_valid), 32'd1);
    chk("f_if_rdata", bus.if_rdata, 32'h00500093);
    chk("f_req_drop", 32'(bus.mem_req), 32'd0);
    bus.if_req = 1'b0;
    step();
    chk("f_valid_pulse", 32'(bus.if_valid), 32'd0);

    // store then load
    drive_d(1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEADBEEF);
    step();
    chk("st_mem_req", 32'(bus.mem_req), 32'd1);
    chk("st_mem_we", 32'(bus.mem_we), 32'd1);
    chk("st_mem_mask", 32'(bus.mem_mask), 32'h3);
    chk("st_mem_addr", bus.mem_addr, 32'h2000);
    chk("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    ack(32'h12345678);
    chk("st_d_valid", 32'(bus.d_valid), 32'd1);
    chk("st_d_rdata", bus.d_rdata, 32'd0);
    drive_d(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    step();
    drive_d(1'b1, 1'b0, 4'd0, 32'h2000, 32'd0);
    step();
    chk("ld_mem_we", 32'(bus.mem_we), 32'd0);
    chk("ld_mem_addr", bus.mem_addr, 32'h2000);
    ack(32'h0000BEEF);
    chk("ld_d_valid", 32'(bus.d_valid), 32'd1);
    chk("ld_d_rdata", bus.d_rdata, 32'h0000BEEF);
    drive_d(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    step();

    // contention with zero-wait ack: expected grant order D,D,D,D,I twice
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(32'h3000);
      exp_q.push_back(32'h400);
    end
    bus.if_req = 1'b1;
    bus.if_addr = 32'h400;
    drive_d(1'b1, 1'b0, 4'd0, 32'h3000, 32'd0);
    for (int g = 0; g < 10; g++) begin
      wait_req("ct_grant", 8);
      chk($sformatf("ct_grant%0d", g), bus.mem_addr, exp_q.pop_front());
      ack(32'h0000AAAA + 32'(g));
    end
    bus.if_req = 1'b0;
    drive_d(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("ct_last_if_valid", 32'(bus.if_valid), 32'd1);
    chk("ct_last_if_rdata", bus.if_rdata, 32'h0000AAB3);
    step();

    // flush of an in-flight fetch, then a normal fetch
    bus.if_req = 1'b1;
    bus.if_addr = 32'h104;
    step();
    chk("fl_mem_addr", bus.mem_addr, 32'h104);
    bus.if_flush = 1'b1;
    step();
    bus.if_flush = 1'b0;
    ack(32'h0BADC0DE);
    chk("fl_no_valid", 32'(bus.if_valid), 32'd0);
    chk("fl_rdata_kept", bus.if_rdata, 32'h0000AAB3);
    bus.if_addr = 32'h200;
    step();
    chk("fl_next_addr", bus.mem_addr, 32'h200);
    chk("fl_next_req", 32'(bus.mem_req), 32'd1);
    ack(32'h00000013);
    chk("fl_next_valid", 32'(bus.if_valid), 32'd1);
    chk("fl_next_rdata", bus.if_rdata, 32'h00000013);
    bus.if_req = 1'b0;
    step();

    // reset in D_BUSY, late ack afterwards, then a fresh data request
    drive_d(1'b1, 1'b0, 4'd0, 32'h5000, 32'd0);
    step();
    chk("rm_busy_req", 32'(bus.mem_req), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rm_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rm_mem_addr", bus.mem_addr, 32'd0);
    chk("rm_if_rdata", bus.if_rdata, 32'd0);
    chk("rm_state", 32'(bus.state_dbg), 32'd0);
    drive_d(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    step();
    rst = 1'b1;
    step();
    ack(32'hFFFF0000);
    chk("rm_late_ack_valid", 32'(bus.d_valid), 32'd0);
    chk("rm_late_ack_req", 32'(bus.mem_req), 32'd0);
    drive_d(1'b1, 1'b1, 4'hF, 32'h6000, 32'h11223344);
    step();
    chk("rm_new_addr", bus.mem_addr, 32'h6000);
    chk("rm_new_we", 32'(bus.mem_we), 32'd1);
    ack(32'd0);
    chk("rm_new_valid", 32'(bus.d_valid), 32'd1);
    drive_d(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    step();

    // holdoff: if_req stays high in the if_valid cycle
    bus.if_req = 1'b1;
    bus.if_addr = 32'h300;
    step();
    chk("ho_addr", bus.mem_addr, 32'h300);
    ack(32'h00000011);
    chk("ho_valid", 32'(bus.if_valid), 32'd1);
    bus.if_addr = 32'h304;
    step();
    chk("ho_no_regrant", 32'(bus.mem_req), 32'd0);
    chk("ho_valid_pulse", 32'(bus.if_valid), 32'd0);
    step();
    chk("ho_regrant", 32'(bus.mem_req), 32'd1);
    chk("ho_regrant_addr", bus.mem_addr, 32'h304);
    ack(32'h00000022);
    chk("ho_second_rdata", bus.if_rdata, 32'h00000022);
    bus.if_req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
